// File: rtl/bias_seq_pkg.sv
// Shared types and sizing for the bias sequencer: lane count, word width, FSM states.
package bias_seq_pkg;
    localparam int QW    = 32;
    localparam int XW    = 4;
    localparam int IDX_W = $clog2(XW);

    typedef enum logic [1:0] {HDR, LOAD, RUN} bias_seq_state_t;
endpackage

// File: rtl/bias_shadow_rf.sv
// XW x QW shadow register file; a commit strobe copies the shadow into the output bank,
// folding in a word written on the same edge.
module bias_shadow_rf
    import bias_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [IDX_W-1:0] idx,
    input  logic [QW-1:0]    wdata,
    input  logic             commit,
    output logic [QW-1:0]    bias [XW]
);
    logic [QW-1:0] shadow [XW];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < XW; k++) begin
                shadow[k] <= '0;
                bias[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < XW; k++) begin
                if (we && idx == IDX_W'(k)) shadow[k] <= wdata;
                // The last lane is written on the commit edge itself, so bypass it.
                if (commit) bias[k] <= (we && idx == IDX_W'(k)) ? wdata : shadow[k];
            end
        end
    end
endmodule

// File: rtl/bias_seq_ctrl.sv
// Loads a header (vector count) plus XW bias words, then passes exactly that many vectors
// downstream before accepting the next set. Data is combinational; only the handshake is gated.
module bias_seq_ctrl
    import bias_seq_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [QW-1:0] cfg_data_i,
    input  logic          cfg_valid_i,
    output logic          cfg_ready_o,
    input  logic [QW-1:0] data_i [XW],
    input  logic          valid_i,
    output logic          ready_o,
    output logic [QW-1:0] data_o [XW],
    output logic          valid_o,
    input  logic          ready_i,
    output logic [QW-1:0] bias_o [XW],
    output logic          set_done_o
);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(XW - 1);

    bias_seq_state_t  state, state_nx;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] remaining;
    logic             cfg_hs, out_hs, sh_we, commit;
    logic             unused_hdr_bits;

    assign cfg_hs          = cfg_valid_i & cfg_ready_o;
    assign out_hs          = valid_o & ready_i;
    assign data_o          = data_i;
    assign unused_hdr_bits = ^cfg_data_i[QW-1:CNT_W];

    always_comb begin
        state_nx    = state;
        cfg_ready_o = 1'b0;
        valid_o     = 1'b0;
        ready_o     = 1'b0;
        sh_we       = 1'b0;
        commit      = 1'b0;
        case (state)
            HDR: begin
                cfg_ready_o = 1'b1;
                if (cfg_valid_i) state_nx = LOAD;
            end
            LOAD: begin
                cfg_ready_o = 1'b1;
                if (cfg_valid_i) begin
                    sh_we = 1'b1;
                    if (idx == IDX_LAST) begin
                        commit   = 1'b1;
                        state_nx = (remaining != '0) ? RUN : HDR;
                    end
                end
            end
            RUN: begin
                valid_o = valid_i;
                ready_o = ready_i;
                if (valid_i && ready_i && remaining == CNT_W'(1)) state_nx = HDR;
            end
            default: state_nx = HDR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= HDR;
            idx        <= '0;
            remaining  <= '0;
            set_done_o <= 1'b0;
        end else begin
            state      <= state_nx;
            set_done_o <= 1'b0;
            case (state)
                HDR: if (cfg_hs) begin
                    remaining <= cfg_data_i[CNT_W-1:0];
                    idx       <= '0;
                end
                LOAD: if (cfg_hs) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
                RUN: if (out_hs) begin
                    remaining  <= remaining - 1'b1;
                    set_done_o <= (remaining == CNT_W'(1));
                end
                default: ;
            endcase
        end
    end

    bias_shadow_rf u_shadow (
        .clk    (clk),
        .rst    (rst),
        .we     (sh_we),
        .idx    (idx),
        .wdata  (cfg_data_i),
        .commit (commit),
        .bias   (bias_o)
    );
endmodule

// File: tb/tb_bias_seq_ctrl.sv
// Directed-plus-random bench for bias_seq_ctrl with a set-level reference model.
module tb_bias_seq_ctrl;
    import bias_seq_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic [QW-1:0] cfg_data_i;
    logic          cfg_valid_i, cfg_ready_o;
    logic [QW-1:0] data_i [XW];
    logic [QW-1:0] data_o [XW];
    logic [QW-1:0] bias_o [XW];
    logic          valid_i, ready_o, valid_o, ready_i, set_done_o;

    int            n_vec = 0;
    int            n_err = 0;
    logic [QW-1:0] exp_bias [XW];
    logic [QW-1:0] exp_q [$];

    always #5 clk = ~clk;

    bias_seq_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .cfg_data_i(cfg_data_i), .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
        .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
        .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
        .bias_o(bias_o), .set_done_o(set_done_o)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [QW-1:0] obs, input logic [QW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Positive integer to IEEE-754 single bit pattern.
    function automatic logic [31:0] float_bits(input int v);
        int e = 0;
        while ((v >> (e + 1)) != 0) e++;
        return {1'b0, 8'(127 + e), 23'((v << (23 - e)) & 32'h007F_FFFF)};
    endfunction

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_data();
        for (int k = 0; k < XW; k++) data_i[k] = $urandom;
    endtask

    task automatic check_common();
        for (int k = 0; k < XW; k++) begin
            check("data_pass", data_o[k], data_i[k]);
            check("bias_hold", bias_o[k], exp_bias[k]);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_cfg_ready"}, cfg_ready_o, 1);
        check({tag, "_valid_o"}, valid_o, 0);
        check({tag, "_ready_o"}, ready_o, 0);
    endtask

    task automatic send_cfg(input logic [QW-1:0] word);
        cfg_valid_i = 1'b1;
        cfg_data_i  = word;
        valid_i     = 1'($urandom_range(0, 1));
        ready_i     = 1'($urandom_range(0, 1));
        rand_data();
        settle();
        check_common();
        check_idle("load");
        check("load_done", set_done_o, 0);
        adv();
        cfg_valid_i = 1'b0;
    endtask

    task automatic stall_cfg(input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            cfg_valid_i = 1'b0;
            cfg_data_i  = $urandom;
            valid_i     = 1'b1;
            ready_i     = 1'b1;
            rand_data();
            settle();
            check_idle("stall");
            adv();
        end
    endtask

    task automatic load_set(input int count, input logic [QW-1:0] b [XW], input int stall_at);
        send_cfg({16'($urandom), 16'(count)});
        for (int k = 0; k < XW; k++) begin
            if (k == stall_at) stall_cfg(5);
            send_cfg(b[k]);
        end
        for (int k = 0; k < XW; k++) exp_bias[k] = b[k];
    endtask

    // mode 0: always ready; 1: random valid/ready; 2: ready pattern 1,0,0,1 with valid held.
    task automatic run_set(input int n, input int mode);
        int  cnt = 0;
        int  cyc = 0;
        bit  pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int v = 0; v < n; v++)
            for (int k = 0; k < XW; k++) exp_q.push_back(exp_bias[k]);
        while (cnt < n && cyc < 200) begin
            valid_i     = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            ready_i     = (mode == 1) ? 1'($urandom_range(0, 1)) :
                          (mode == 2) ? pat[cyc % 4] : 1'b1;
            cfg_valid_i = 1'($urandom_range(0, 1));
            cfg_data_i  = $urandom;
            rand_data();
            settle();
            check_common();
            check("run_valid_o", valid_o, valid_i);
            check("run_ready_o", ready_o, ready_i);
            check("run_cfg_ready", cfg_ready_o, 0);
            check("run_done_early", set_done_o, 0);
            if (valid_i && ready_i) begin
                cnt++;
                for (int k = 0; k < XW; k++) check("vec_bias", bias_o[k], exp_q.pop_front());
            end
            adv();
            cyc++;
        end
        check("run_transfers", cnt, n);
        cfg_valid_i = 1'b0;
        valid_i     = 1'b1;
        ready_i     = 1'b1;
        settle();
        check("set_done_pulse", set_done_o, 1);
        check_idle("after_run");
        adv();
        settle();
        check("set_done_clear", set_done_o, 0);
        check_idle("hdr_wait");
        adv();
    endtask

    task automatic reset_async(input string tag);
        #1 rst = 1'b1;
        #1;
        for (int k = 0; k < XW; k++) exp_bias[k] = '0;
        exp_q.delete();
        check_common();
        check_idle(tag);
        check({tag, "_done"}, set_done_o, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        adv();
    endtask

    logic [QW-1:0] b [XW];
    logic [QW-1:0] b2 [XW];
    logic [QW-1:0] wq [$];
    int            hs_cyc [$];
    int            n_done;

    initial begin
        rst = 1'b1;
        cfg_valid_i = 1'b0; cfg_data_i = '0; valid_i = 1'b1; ready_i = 1'b1;
        rand_data();
        for (int k = 0; k < XW; k++) exp_bias[k] = '0;
        repeat (2) adv();
        settle();
        check_common();
        check_idle("reset");
        check("reset_done", set_done_o, 0);
        adv();
        rst = 1'b0;
        adv();

        // Basic: count 3, biases 1.0 .. XW.0
        for (int k = 0; k < XW; k++) b[k] = float_bits(k + 1);
        load_set(3, b, -1);
        run_set(3, 0);

        // Backpressure on ready_i
        for (int k = 0; k < XW; k++) b[k] = $urandom;
        load_set(2, b, -1);
        run_set(2, 2);

        // Zero count: bias updates, nothing flows, no done pulse
        for (int k = 0; k < XW; k++) b[k] = $urandom;
        load_set(0, b, -1);
        for (int c = 0; c < 4; c++) begin
            valid_i = 1'b1; ready_i = 1'b1; rand_data();
            settle();
            check_common();
            check_idle("zero_cnt");
            check("zero_done", set_done_o, 0);
            adv();
        end

        // Config stall mid-load, then random sets with config pressure during RUN
        for (int s = 0; s < 4; s++) begin
            int n;
            n = $urandom_range(1, 5);
            for (int k = 0; k < XW; k++) b[k] = $urandom;
            load_set(n, b, (s == 0) ? XW / 2 : $urandom_range(0, XW));
            run_set(n, 1);
        end

        // Reset mid-load
        send_cfg(32'd4);
        for (int k = 0; k < XW / 2; k++) send_cfg($urandom);
        reset_async("rst_load");

        // Full set, reset mid-run, then full set again
        for (int k = 0; k < XW; k++) b[k] = $urandom;
        load_set(5, b, -1);
        for (int c = 0; c < 2; c++) begin
            valid_i = 1'b1; ready_i = 1'b1; rand_data();
            settle();
            check("partial_valid", valid_o, 1);
            adv();
        end
        reset_async("rst_run");
        for (int k = 0; k < XW; k++) b[k] = $urandom;
        load_set(2, b, -1);
        run_set(2, 1);

        // Back-to-back single-vector sets with config and data held valid
        for (int k = 0; k < XW; k++) begin
            b[k]  = $urandom;
            b2[k] = $urandom;
        end
        wq.push_back(32'd1);
        for (int k = 0; k < XW; k++) wq.push_back(b[k]);
        wq.push_back(32'd1);
        for (int k = 0; k < XW; k++) wq.push_back(b2[k]);
        for (int k = 0; k < XW; k++) exp_q.push_back(b[k]);
        for (int k = 0; k < XW; k++) exp_q.push_back(b2[k]);
        n_done = 0;
        for (int c = 0; c < 30; c++) begin
            valid_i     = 1'b1;
            ready_i     = 1'b1;
            cfg_valid_i = (wq.size() > 0);
            cfg_data_i  = (wq.size() > 0) ? wq[0] : '0;
            rand_data();
            settle();
            if (set_done_o) n_done++;
            if (valid_o && ready_i) begin
                hs_cyc.push_back(c);
                for (int k = 0; k < XW; k++)
                    if (exp_q.size() > 0) check("b2b_bias", bias_o[k], exp_q.pop_front());
            end
            if (cfg_valid_i && cfg_ready_o) void'(wq.pop_front());
            adv();
        end
        check("b2b_vectors", hs_cyc.size(), 2);
        check("b2b_done_pulses", n_done, 2);
        if (hs_cyc.size() == 2) check("b2b_gap", hs_cyc[1] - hs_cyc[0] - 1, XW + 1);
        check("b2b_cfg_drained", wq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
